// File: rtl/sort_frame_loader.sv
// Byte-stream front end for the 5-input sorter: gathers 5 bytes into a frame,
// holds it stable for SORT_CYCLES cycles, then pulses sort_done.
module sort_frame_loader #(
  parameter int WIDTH       = 8,
  parameter int SORT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic             frame_valid,
  output logic             sort_done,
  output logic [7:0]       frame_count
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_HOLD    = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(SORT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       hold_q, hold_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] stg_q [4];
  logic [WIDTH-1:0] out_q [5];

  logic accept;
  logic stage_wr;
  logic load_frame;

  assign accept = in_valid && (state_q == S_COLLECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_COLLECT;
      idx_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    stage_wr   = 1'b0;
    load_frame = 1'b0;
    case (state_q)
      S_COLLECT: begin
        // flush beats a coincident byte: the byte is consumed but dropped
        if (flush) begin
          idx_d = '0;
        end else if (accept) begin
          if (idx_q == 3'd4) begin
            load_frame = 1'b1;
            idx_d      = '0;
            hold_d     = HOLD_INIT;
            state_d    = S_HOLD;
          end else begin
            stage_wr = 1'b1;
            idx_d    = idx_q + 3'd1;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == 8'd0) begin
          state_d = S_DONE;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_COLLECT;
      default: state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == S_COLLECT);
    frame_valid = (state_q == S_HOLD) || (state_q == S_DONE);
    sort_done   = (state_q == S_DONE);
  end

  // All five outputs update on the same edge so the sorter never sees a mixed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stg_q[i] <= '0;
      for (int i = 0; i < 5; i++) out_q[i] <= '0;
    end else begin
      if (stage_wr) stg_q[idx_q[1:0]] <= in_data;
      if (load_frame) begin
        for (int i = 0; i < 4; i++) out_q[i] <= stg_q[i];
        out_q[4] <= in_data;
      end
    end
  end

  assign out1        = out_q[0];
  assign out2        = out_q[1];
  assign out3        = out_q[2];
  assign out4        = out_q[3];
  assign out5        = out_q[4];
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Bench for sort_frame_loader: two instances (SORT_CYCLES=4 and 1) share one
// stimulus stream and are checked every cycle against a countdown/queue model.
module tb_sort_frame_loader;

  localparam int SCA = 4;
  localparam int SCB = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;

  logic [7:0] a_o1, a_o2, a_o3, a_o4, a_o5, a_fc;
  logic       a_ir, a_fv, a_sd;
  logic [7:0] b_o1, b_o2, b_o3, b_o4, b_o5, b_fc;
  logic       b_ir, b_fv, b_sd;

  always #5 clk = ~clk;

  sort_frame_loader #(.WIDTH(8), .SORT_CYCLES(SCA)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_ir),
    .flush(flush), .out1(a_o1), .out2(a_o2), .out3(a_o3), .out4(a_o4), .out5(a_o5),
    .frame_valid(a_fv), .sort_done(a_sd), .frame_count(a_fc));

  sort_frame_loader #(.WIDTH(8), .SORT_CYCLES(SCB)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_ir),
    .flush(flush), .out1(b_o1), .out2(b_o2), .out3(b_o3), .out4(b_o4), .out5(b_o5),
    .frame_valid(b_fv), .sort_done(b_sd), .frame_count(b_fc));

  // Model: bytes pile up in a buffer; a completed frame starts a busy countdown
  // of SC+1 cycles (SC hold cycles, then one done cycle).
  int         m_n   [2];
  int         m_rem [2];
  logic [7:0] m_cnt [2];
  logic [7:0] m_stg [2][4];
  logic [7:0] m_out [2][5];

  function automatic int scv(input int k);
    return (k == 0) ? SCA : SCB;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_n[k]   <= 0;
        m_rem[k] <= 0;
        m_cnt[k] <= '0;
        for (int j = 0; j < 4; j++) m_stg[k][j] <= '0;
        for (int j = 0; j < 5; j++) m_out[k][j] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_rem[k] != 0) begin
          m_rem[k] <= m_rem[k] - 1;
          if (m_rem[k] == 2) m_cnt[k] <= m_cnt[k] + 8'd1;
        end else if (flush) begin
          m_n[k] <= 0;
        end else if (in_valid) begin
          if (m_n[k] < 4) begin
            m_stg[k][m_n[k]] <= in_data;
            m_n[k] <= m_n[k] + 1;
          end else begin
            for (int j = 0; j < 4; j++) m_out[k][j] <= m_stg[k][j];
            m_out[k][4] <= in_data;
            m_n[k]   <= 0;
            m_rem[k] <= scv(k) + 1;
          end
        end
      end
    end
  end

  function automatic logic [50:0] exp_pack(input int k);
    return {m_out[k][0], m_out[k][1], m_out[k][2], m_out[k][3], m_out[k][4],
            (m_rem[k] != 0), (m_rem[k] == 1), (m_rem[k] == 0), m_cnt[k]};
  endfunction

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dutA_cycle", 64'({a_o1, a_o2, a_o3, a_o4, a_o5, a_fv, a_sd, a_ir, a_fc}), 64'(exp_pack(0)));
      chk("dutB_cycle", 64'({b_o1, b_o2, b_o3, b_o4, b_o5, b_fv, b_sd, b_ir, b_fc}), 64'(exp_pack(1)));
    end
  end

  // Offers a byte until dut_a accepts it; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] d, input int gap, input logic fl);
    int t;
    in_data  = d;
    in_valid = 1'b1;
    flush    = fl;
    t = 0;
    @(negedge clk);
    while (!a_ir && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 64'(t), 64'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f, input int gap);
    logic [39:0] v;
    v = f;
    for (int i = 0; i < 5; i++) send(v[39-8*i -: 8], gap, 1'b0);
  endtask

  initial begin
    logic [7:0] srt [5];
    logic [7:0] tmp;
    int k, pulses, low, cyc;
    logic [7:0] fc_end;

    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    chk("reset_ready", 64'(a_ir), 64'(1));
    chk("reset_outs", 64'({a_o1, a_o2, a_o3, a_o4, a_o5, a_fv, a_sd, a_fc}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: back-to-back frame, latency of sort_done and in_ready
    send_frame({8'd16, 8'd14, 8'd15, 8'd17, 8'd12}, 0);
    chk("t1_frame", 64'({a_o1, a_o2, a_o3, a_o4, a_o5}), 64'({8'd16, 8'd14, 8'd15, 8'd17, 8'd12}));
    chk("t1_fv", 64'({a_fv, a_ir}), 64'(2'b10));
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!a_sd && k < 20);
    chk("t1_done_lat", 64'(k), 64'(4));
    chk("t1_count", 64'(a_fc), 64'(1));
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!a_ir && k < 20);
    chk("t1_ready_lat", 64'(k), 64'(5));
    srt = '{a_o1, a_o2, a_o3, a_o4, a_o5};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4 - i; j++)
        if (srt[j] > srt[j+1]) begin
          tmp = srt[j]; srt[j] = srt[j+1]; srt[j+1] = tmp;
        end
    chk("t1_sorted", 64'({srt[0], srt[1], srt[2], srt[3], srt[4]}), 64'({8'd12, 8'd14, 8'd15, 8'd16, 8'd17}));
    @(posedge clk);
    #1;

    // 2: gapped stream after reset
    reset_pulse();
    send(8'd16, 2, 1'b0); send(8'd14, 2, 1'b0); send(8'd15, 2, 1'b0); send(8'd17, 2, 1'b0);
    chk("t2_partial", 64'({a_o1, a_o2, a_o3, a_o4, a_o5, a_fv}), 64'(0));
    send(8'd12, 0, 1'b0);
    chk("t2_frame", 64'({a_o1, a_o2, a_o3, a_o4, a_o5, a_fv}), 64'({8'd16, 8'd14, 8'd15, 8'd17, 8'd12, 1'b1}));

    // 3: flush alone, then flush coincident with a byte
    send(8'd3, 0, 1'b0); send(8'd9, 0, 1'b0); send(8'd1, 0, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    send_frame({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0);
    chk("t3_frame", 64'({a_o1, a_o2, a_o3, a_o4, a_o5}), 64'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}));
    for (int i = 0; i < 4; i++) send(8'd7, 0, 1'b0);
    send(8'd2, 0, 1'b1);
    send(8'd5, 0, 1'b0); send(8'd4, 0, 1'b0); send(8'd3, 0, 1'b0); send(8'd2, 0, 1'b0);
    chk("t3_dropped", 64'(a_fv), 64'(0));
    send(8'd1, 0, 1'b0);
    chk("t3_frame2", 64'({a_o1, a_o2, a_o3, a_o4, a_o5, a_fv}), 64'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 1'b1}));

    // 4: valid held during hold window
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t4_hold", 64'({a_o1, a_o2, a_o3, a_o4, a_o5, a_ir}), 64'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 1'b0}));
    in_valid = 1'b0;
    send_frame({8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 0);
    chk("t4_next", 64'({a_o1, a_o2, a_o3, a_o4, a_o5}), 64'({8'd1, 8'd2, 8'd3, 8'd4, 8'd5}));

    // 5: asynchronous reset in the second hold cycle
    send_frame({8'd16, 8'd14, 8'd15, 8'd17, 8'd12}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_async", 64'({a_o1, a_o2, a_o3, a_o4, a_o5, a_fv, a_sd, a_fc}), 64'(0));
    chk("t5_ready", 64'(a_ir), 64'(1));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // 6: 256 back-to-back random frames on the SORT_CYCLES=1 instance
    reset_pulse();
    pulses = 0; low = 0; cyc = 0; fc_end = 8'hFF;
    in_valid = 1'b1;
    while (pulses < 256 && cyc < 4000) begin
      in_data = 8'($urandom);
      @(negedge clk);
      if (!b_ir) low++;
      if (b_sd) begin
        pulses++;
        if (pulses == 256) fc_end = b_fc;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("t6_pulses", 64'(pulses), 64'(256));
    chk("t6_wrap", 64'(fc_end), 64'(0));
    chk("t6_low", 64'(low), 64'(512));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sort_frame_loader.md
Name: sort_frame_loader

Overview:
Upstream stage of the 5-input bubblesort block. It accepts a byte stream over a valid/ready handshake and assembles 5 consecutive bytes into one frame. It then presents the frame atomically on out1..out5, which drive the sorter's in1..in5, and holds it stable for a fixed number of sort cycles. After the hold it pulses sort_done and accepts the next frame.

Parameters:
WIDTH, 8, data width of each element (matches sorter element width)
SORT_CYCLES, 4, cycles the frame is held stable for the sorter; legal range 1..255

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  stream byte
in_valid  input  1  in_data valid this cycle
in_ready  output  1  loader can accept a byte; transfer occurs when in_valid && in_ready at rising clk
flush  input  1  discards a partially collected frame
out1..out5  output  WIDTH each  frame elements in arrival order (out1 = first byte); drive sorter in1..in5
frame_valid  output  1  out1..out5 hold a complete, stable frame
sort_done  output  1  one-cycle pulse at end of hold window
frame_count  output  8  number of completed frames, wraps 255->0

Behaviour:
- Reset (async, immediate): state=COLLECT, byte index=0, staging regs=0, out1..out5=0, frame_valid=0, sort_done=0, frame_count=0, hold counter=0.
- in_ready=1 exactly when state==COLLECT (decoded from the state register, no dependence on in_valid). After reset it is therefore 1.
- COLLECT:
  - On each accepted byte with index 0..3: store the byte in staging[index] and increment index.
  - On the accepted byte with index 4: copy staging[0..3] to out1..out4 and in_data to out5, all on the same edge. Reset index to 0, load the hold counter with SORT_CYCLES-1, go to HOLD.
  - out1..out5 never change except on this edge, so the frame update is atomic.
- HOLD:
  - frame_valid=1 and in_ready=0.
  - The counter decrements each cycle. When the counter==0 at a rising edge, go to DONE.
  - HOLD therefore lasts exactly SORT_CYCLES cycles.
- DONE:
  - Lasts exactly 1 cycle, with frame_valid=1 and sort_done=1.
  - frame_count increments on the edge entering DONE.
  - The next edge goes to COLLECT.
- Latency: frame_valid rises on the edge that accepts byte 5. sort_done rises SORT_CYCLES edges later. in_ready returns SORT_CYCLES+1 edges after byte 5 is accepted.
- frame_valid falls on the DONE->COLLECT edge. out1..out5 keep their last frame until the next complete frame arrives.
- flush:
  - In COLLECT, flush sets index=0 and discards staging contents (staging need not be cleared).
  - If flush and an accepted byte occur in the same cycle, flush wins and the byte is dropped. in_ready is still 1, so the producer considers it consumed.
  - In HOLD and DONE, flush is ignored.
- in_valid while in_ready=0: no transfer. in_data is not sampled, and the producer must hold it.
- Reset asserted mid-frame or mid-hold: state returns to COLLECT immediately, the partial frame is lost, and no sort_done is emitted.
- frame_count: 8-bit unsigned modulo 256.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then stream 16,14,15,17,12 with in_valid held high, SORT_CYCLES=4 -> out1..out5=16,14,15,17,12 on the 5th accept edge; frame_valid=1; sort_done high exactly 4 cycles after that edge; frame_count=1; in_ready=1 again 5 cycles after byte 5; downstream sorter outputs 12,14,15,16,17.
2. Same bytes sent with in_valid deasserted for 2 cycles between each byte -> identical frame; out1..out5 stay 0 until the 5th accept; frame_valid stays 0 during gaps.
3. Send 3,9,1, assert flush, then send 5,4,3,2,1 -> frame=5,4,3,2,1; 3,9,1 never appear; flush coincident with byte '2' drops it, so the frame completes only after the next byte.
4. Hold in_valid=1 with data 0xAA during HOLD -> no transfer, in_ready=0, outputs unchanged; next frame starts cleanly in COLLECT.
5. Assert rst in the 2nd HOLD cycle -> all outputs 0 immediately (asynchronous), no sort_done pulse, frame_count=0, in_ready=1.
6. Run 256 back-to-back frames with SORT_CYCLES=1 -> frame_count wraps to 0; each frame has a 1-cycle HOLD and a 1-cycle DONE; in_ready is low for exactly 2 cycles per frame.
